// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand selection feeding the ALU.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB result forwarding.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_reg_we,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic [2:0]      id_alu_op,
  input  logic            exmem_we,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_we,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_we,
  output logic [2:0]      ALU_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] ex_store_data
);

  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [REGW-1:0] ex_rs1;
  logic [REGW-1:0] ex_rs2;
  logic            ex_a_sel;
  logic            ex_b_sel;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Flush wins over stall; a bubble zeroes every field so the ALU sees ADD 0,0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_reg_we   <= 1'b0;
      ex_a_sel    <= 1'b0;
      ex_b_sel    <= 1'b0;
      ALU_op      <= 3'b000;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_reg_we   <= 1'b0;
      ex_a_sel    <= 1'b0;
      ex_b_sel    <= 1'b0;
      ALU_op      <= 3'b000;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_reg_we   <= id_reg_we & id_valid;
      ex_a_sel    <= id_a_sel;
      ex_b_sel    <= id_b_sel;
      ALU_op      <= id_alu_op;
    end
  end

`ifdef ID_EX_FWD_EN
  // Re-evaluated every cycle, so a stalled instruction picks up results as they retire.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (ex_rs1 != '0 && exmem_we && exmem_rd == ex_rs1)
      fwd_rs1 = exmem_result;
    else if (ex_rs1 != '0 && memwb_we && memwb_rd == ex_rs1)
      fwd_rs1 = memwb_result;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (ex_rs2 != '0 && exmem_we && exmem_rd == ex_rs2)
      fwd_rs2 = exmem_result;
    else if (ex_rs2 != '0 && memwb_we && memwb_rd == ex_rs2)
      fwd_rs2 = memwb_result;
  end
`else
  logic unused_fwd;
  assign fwd_rs1    = ex_rs1_data;
  assign fwd_rs2    = ex_rs2_data;
  assign unused_fwd = ^{exmem_we, exmem_rd, exmem_result,
                        memwb_we, memwb_rd, memwb_result, ex_rs1, ex_rs2};
`endif

  assign alu_a         = ex_a_sel ? ex_pc  : fwd_rs1;
  assign alu_b         = ex_b_sel ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized checks of id_ex_stage against a transaction-level model.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall, flush, id_valid, id_reg_we, id_a_sel, id_b_sel;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]      id_alu_op;
  logic            exmem_we, memwb_we;
  logic [REGW-1:0] exmem_rd, memwb_rd;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            ex_valid, ex_reg_we;
  logic [XLEN-1:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [REGW-1:0] ex_rd;
  logic [2:0]      ALU_op;

  int compared = 0;
  int mismatched = 0;

  // The instruction currently believed to sit in EX.
  typedef struct {
    logic            valid;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [REGW-1:0] rs1, rs2, rd;
    logic            we, a_sel, b_sel;
    logic [2:0]      op;
  } instr_t;
  instr_t m;

  id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_we(id_reg_we),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_op(id_alu_op),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ALU_op(ALU_op), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  function automatic instr_t empty_instr();
    instr_t e;
    e.valid = 0; e.pc = '0; e.rs1_data = '0; e.rs2_data = '0; e.imm = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.we = 0; e.a_sel = 0; e.b_sel = 0;
    e.op = 3'b000;
    return e;
  endfunction

  // Value an instruction reading register rs should see right now.
  function automatic logic [XLEN-1:0] source_value(input logic [REGW-1:0] rs,
                                                   input logic [XLEN-1:0] rf);
`ifdef ID_EX_FWD_EN
    if (rs != 0 && exmem_we && exmem_rd == rs) return exmem_result;
    if (rs != 0 && memwb_we && memwb_rd == rs) return memwb_result;
`endif
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [XLEN-1:0] a, b, s;
    s = source_value(m.rs2, m.rs2_data);
    a = m.a_sel ? m.pc  : source_value(m.rs1, m.rs1_data);
    b = m.b_sel ? m.imm : s;
    chk({tag, ".ex_valid"}, XLEN'(ex_valid), XLEN'(m.valid));
    chk({tag, ".ex_pc"}, ex_pc, m.pc);
    chk({tag, ".ex_rd"}, XLEN'(ex_rd), XLEN'(m.rd));
    chk({tag, ".ex_reg_we"}, XLEN'(ex_reg_we), XLEN'(m.we));
    chk({tag, ".ALU_op"}, XLEN'(ALU_op), XLEN'(m.op));
    chk({tag, ".alu_a"}, alu_a, a);
    chk({tag, ".alu_b"}, alu_b, b);
    chk({tag, ".store"}, ex_store_data, s);
  endtask

  // One rising edge; the model applies the pipeline-register rules to what was driven.
  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush) m = empty_instr();
    else if (!stall) begin
      m.valid = id_valid; m.pc = id_pc; m.rs1_data = id_rs1_data;
      m.rs2_data = id_rs2_data; m.imm = id_imm; m.rs1 = id_rs1; m.rs2 = id_rs2;
      m.rd = id_rd; m.we = id_reg_we && id_valid; m.a_sel = id_a_sel;
      m.b_sel = id_b_sel; m.op = id_alu_op;
    end
    #1;
  endtask

  task automatic drive_random_id();
    id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
    id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = REGW'($urandom_range(0, 3)); id_rs2 = REGW'($urandom_range(0, 3));
    id_rd = REGW'($urandom); id_reg_we = 1'($urandom); id_a_sel = 1'($urandom);
    id_b_sel = 1'($urandom); id_alu_op = 3'($urandom);
  endtask

  task automatic drive_random_fwd();
    exmem_we = 1'($urandom); exmem_rd = REGW'($urandom_range(0, 3)); exmem_result = $urandom;
    memwb_we = 1'($urandom); memwb_rd = REGW'($urandom_range(0, 3)); memwb_result = $urandom;
  endtask

  initial begin
    m = empty_instr();
    rst_n = 0; stall = 0; flush = 0;
    drive_random_id();
    drive_random_fwd();
    #2;
    check_all("reset");
    chk("reset.alu_a_zero", alu_a, 32'h0);

    // Basic capture: rs1 + imm.
    #20; rst_n = 1;
    exmem_we = 0; memwb_we = 0;
    id_valid = 1; id_rs1 = 5'd1; id_rs1_data = 32'd5; id_imm = 32'd7;
    id_a_sel = 0; id_b_sel = 1; id_alu_op = 3'b000; id_pc = 32'h40;
    tick();
    chk("t1.alu_a", alu_a, 32'd5);
    chk("t1.alu_b", alu_b, 32'd7);
    chk("t1.ALU_op", XLEN'(ALU_op), 32'd0);
    chk("t1.ex_valid", XLEN'(ex_valid), 32'd1);

    // Forwarding priority on rs1 = x3.
    id_rs1 = 5'd3; id_rs1_data = 32'd1; id_a_sel = 0;
    tick();
    exmem_we = 1; exmem_rd = 5'd3; exmem_result = 32'h10;
    memwb_we = 1; memwb_rd = 5'd3; memwb_result = 32'h20;
    #1;
`ifdef ID_EX_FWD_EN
    chk("t2.exmem_prio", alu_a, 32'h10);
`else
    chk("t2.no_fwd", alu_a, 32'h1);
`endif
    exmem_we = 0; #1;
`ifdef ID_EX_FWD_EN
    chk("t2.memwb", alu_a, 32'h20);
`else
    chk("t2.no_fwd_memwb", alu_a, 32'h1);
`endif
    check_all("t2");

    // x0 is never forwarded.
    id_rs2 = 5'd0; id_rs2_data = 32'd0; id_b_sel = 0;
    tick();
    exmem_we = 1; exmem_rd = 5'd0; exmem_result = 32'hFFFF; #1;
    chk("t3.alu_b", alu_b, 32'd0);
    chk("t3.store", ex_store_data, 32'd0);

    // Multi-cycle stall holds instruction A.
    id_pc = 32'h100; id_alu_op = 3'd3; id_rd = 5'd7; id_valid = 1; id_reg_we = 1;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_random_id();
      tick();
      chk("t4.hold_pc", ex_pc, 32'h100);
      chk("t4.hold_op", XLEN'(ALU_op), 32'd3);
      chk("t4.hold_rd", XLEN'(ex_rd), 32'd7);
      check_all("t4");
    end
    stall = 0; id_pc = 32'h200;
    tick();
    chk("t4.release_pc", ex_pc, 32'h200);

    // Flush overrides stall.
    stall = 1; flush = 1; drive_random_fwd();
    tick();
    chk("t5.valid", XLEN'(ex_valid), 32'd0);
    chk("t5.reg_we", XLEN'(ex_reg_we), 32'd0);
    chk("t5.alu_a", alu_a, 32'd0);
    chk("t5.alu_b", alu_b, 32'd0);
    stall = 0; flush = 0;

    // Asynchronous reset mid-stall.
    drive_random_id(); id_valid = 1; id_reg_we = 1; id_alu_op = 3'd5;
    tick();
    check_all("t6.pre");
    stall = 1; #2; rst_n = 0; #1;
    m = empty_instr();
    chk("t6.valid", XLEN'(ex_valid), 32'd0);
    chk("t6.reg_we", XLEN'(ex_reg_we), 32'd0);
    chk("t6.ALU_op", XLEN'(ALU_op), 32'd0);
    check_all("t6.async");
    #10; rst_n = 1; stall = 0; drive_random_id();
    tick();
    check_all("t6.post");

    // Randomized traffic with mid-cycle forwarding updates.
    for (int i = 0; i < 300; i++) begin
      drive_random_id();
      drive_random_fwd();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      check_all("rand");
      drive_random_fwd(); #1;
      check_all("rand_fwd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the pipelined RISC-V core.
- Captures decoded instruction fields from ID and holds them across stalls.
- Inserts bubbles on flush and resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Drives alu_a, alu_b and ALU_op directly into the ALU.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold ID/EX contents
- flush  in  1  replace next contents with bubble
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data  in  XLEN  register-file read data for rs1
- id_rs2_data  in  XLEN  register-file read data for rs2
- id_imm  in  XLEN  sign-extended immediate
- id_rs1  in  REGW  source register index 1
- id_rs2  in  REGW  source register index 2
- id_rd  in  REGW  destination register index
- id_reg_we  in  1  instruction writes rd
- id_a_sel  in  1  0=rs1, 1=pc
- id_b_sel  in  1  0=rs2, 1=imm
- id_alu_op  in  3  ALU opcode (000 ADD .. 111 SRA)
- exmem_we  in  1  EX/MEM writes a register
- exmem_rd  in  REGW  EX/MEM destination register
- exmem_result  in  XLEN  EX/MEM result
- memwb_we  in  1  MEM/WB writes a register
- memwb_rd  in  REGW  MEM/WB destination register
- memwb_result  in  XLEN  MEM/WB result
- ex_valid  out  1  EX stage holds a real instruction
- ex_pc  out  XLEN  registered PC
- ex_rd  out  REGW  registered destination register
- ex_reg_we  out  1  registered write enable, gated by ex_valid
- ALU_op  out  3  registered ALU opcode
- alu_a  out  XLEN  ALU operand A (combinational)
- alu_b  out  XLEN  ALU operand B (combinational)
- ex_store_data  out  XLEN  forwarded rs2 value, used by stores

Behaviour:
- Reset (rst_n low, async): all registered fields 0.
  - ex_valid=0, ex_reg_we=0, ALU_op=000.
  - alu_a, alu_b, ex_store_data evaluate to 0.
- Each rising edge:
  - flush=1: load bubble (valid=0, reg_we=0, rd=0, ALU_op=000, data 0). Flush overrides stall.
  - else stall=1: hold all registers unchanged.
  - else: capture all id_* fields. ex_valid=id_valid; ex_reg_we=id_reg_we&id_valid.
- Latency: one cycle from ID capture to operands at ALU.
- Forwarding (combinational, per source rs1/rs2 independently):
  - Use exmem_result if exmem_we, exmem_rd==rs, rs!=0.
  - Else memwb_result if memwb_we, memwb_rd==rs, rs!=0.
  - Else the registered rf data.
  - EX/MEM has priority when both match.
  - x0 never forwarded; x0 reads the registered data, which the register file supplies as 0.
- Operand select:
  - alu_a = a_sel ? ex_pc : fwd_rs1.
  - alu_b = b_sel ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 regardless of b_sel.
- Bubble: ALU_op=ADD with zero operands, so alu_c=0. Downstream ignores it via ex_valid=0.
- Stall held multiple cycles: forwarding re-evaluates every cycle against current exmem/memwb inputs, so a stalled instruction picks up results as they retire.
- Load-use hazard detection is external and is expressed only through stall/flush.
- Reset asserted mid-stall clears contents immediately; first post-reset edge captures normally.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - Forwarding muxes removed; fwd_rs1/fwd_rs2 are the registered rf data.
  - exmem_*/memwb_* ports remain present but are unused.
  - Hazards must then be covered by external stalls.

Test Plan:
1. Reset, then id_valid=1, rs1_data=5, imm=7, b_sel=1, alu_op=000, edge -> alu_a=5, alu_b=7, ALU_op=000, ex_valid=1.
2. Captured rs1=x3 with rs1_data=1; exmem_we=1, exmem_rd=3, exmem_result=0x10 and memwb_we=1, memwb_rd=3, memwb_result=0x20 -> alu_a=0x10. Drop exmem_we -> alu_a=0x20.
3. Captured rs2=x0 with rs2_data=0; exmem_we=1, exmem_rd=0, exmem_result=0xFFFF -> alu_b=0, ex_store_data=0.
4. Capture instr A, then stall=1 for 3 cycles while id_* changes -> ex_pc/ALU_op/ex_rd stay at A's values; stall=0 -> next instruction captured.
5. stall=1 and flush=1 same edge -> ex_valid=0, ex_reg_we=0, alu_a=alu_b=0.
6. rst_n low asynchronously mid-cycle with ex_valid=1 -> ex_valid, ex_reg_we and ALU_op go to 0 before the next edge. With ID_EX_FWD_EN undefined, rerun scenario 2 -> alu_a=1.
